// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mult_arb_pkg;

    localparam int unsigned OP_W        = 8;
    localparam int unsigned PROD_W      = 16;
    localparam int unsigned TIMEOUT_MAX = 255;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone,
        StResp
    } state_e;

    // One-hot acknowledge vector for a grant index.
    function automatic logic [1:0] grant_onehot(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and shared-multiplier signals of mult_arbiter.
// master: the arbiter side; slave: requesters plus multiplier controller.
interface mult_arbiter_if;
    import mult_arb_pkg::*;

    logic [1:0]        req;
    logic [OP_W-1:0]   a0;
    logic [OP_W-1:0]   b0;
    logic [OP_W-1:0]   a1;
    logic [OP_W-1:0]   b1;
    logic [1:0]        ack;
    logic [PROD_W-1:0] result;
    logic              err;
    logic              busy;
    logic              start_mul;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [PROD_W-1:0] mul_p;
    logic              done_mul;

    modport master (
        input  req, a0, b0, a1, b1, mul_p, done_mul,
        output ack, result, err, busy, start_mul, mul_a, mul_b
    );

    modport slave (
        output req, a0, b0, a1, b1, mul_p, done_mul,
        input  ack, result, err, busy, start_mul, mul_a, mul_b
    );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational 2-way round-robin selector: on a tie the index not granted last wins.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Pick a requester from the request vector and the previous grant.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one shared sequential multiplier.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort a stuck operation with err=1.
module mult_arbiter
    import mult_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mult_arbiter_if.master bus
);

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [OP_W-1:0]   mul_a_q, mul_a_d;
    logic [OP_W-1:0]   mul_b_q, mul_b_d;
    logic [PROD_W-1:0] result_q, result_d;
    logic              pick_grant;
    logic              pick_valid;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [7:0] WdMax = 8'(TIMEOUT_MAX);
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;
`endif

    rr_pick u_rr_pick (
        .req   (bus.req),
        .last  (last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // State and datapath registers; rst discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state logic: grant, start, wait for done to fall then rise, respond.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        result_d = result_q;
`ifdef MULT_ARB_TIMEOUT_EN
        wd_d     = wd_q;
        // err is only ever high during the RESP cycle of an aborted operation
        err_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    mul_a_d = pick_grant ? bus.a1 : bus.a0;
                    mul_b_d = pick_grant ? bus.b1 : bus.b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StWaitBusy;
`ifdef MULT_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            StWaitBusy: begin
                // done_mul is still high from the previous idle period; wait for it to drop
                if (!bus.done_mul) begin
                    state_d = StWaitDone;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                if (wd_q == WdMax) begin
                    state_d  = StResp;
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            StWaitDone: begin
                if (bus.done_mul) begin
                    state_d  = StResp;
                    result_d = bus.mul_p;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (wd_q == WdMax) begin
                    state_d  = StResp;
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            StResp: begin
                last_d  = grant_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.start_mul = (state_q == StStart);
    assign bus.ack       = (state_q == StResp) ? grant_onehot(grant_q) : 2'b00;
    assign bus.busy      = (state_q != StIdle);
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.result    = result_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural shared-multiplier model.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_arbiter_if bus ();

    mult_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Multiplier model: start drops done for mul_lat cycles, then raises it with the product.
    int mul_lat   = 4;
    bit mul_stuck = 1'b0;
    int mul_cnt   = 0;

    always @(posedge clk) begin
        if (rst) begin
            bus.done_mul <= 1'b1;
            bus.mul_p    <= '0;
            mul_cnt      <= 0;
        end else if (bus.start_mul) begin
            bus.mul_p    <= {8'b0, bus.mul_a} * {8'b0, bus.mul_b};
            bus.done_mul <= 1'b0;
            mul_cnt      <= mul_stuck ? 0 : mul_lat;
        end else if (mul_cnt > 0) begin
            mul_cnt <= mul_cnt - 1;
            if (mul_cnt == 1) bus.done_mul <= 1'b1;
        end
    end

    // Reference: index granted last (1 after reset so requester 0 wins the first tie).
    logic ref_last = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int limit, output logic [1:0] seen, output int cyc,
                            output int starts);
        seen   = 2'b00;
        cyc    = 0;
        starts = 0;
        while (cyc < limit && seen == 2'b00) begin
            @(negedge clk);
            cyc++;
            if (bus.start_mul) starts++;
            seen = bus.ack;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        ref_last = 1'b1;
    endtask

    // One full transaction; input operands are scrambled mid-operation to prove latching.
    task automatic serve(input logic [1:0] r, input int lat, input logic [7:0] a0v,
                         input logic [7:0] b0v, input logic [7:0] a1v, input logic [7:0] b1v,
                         input string tag);
        logic [1:0] seen;
        int         cyc, starts, g;
        logic [7:0] ea, eb;
        int         exp_p;
        bus.a0  = a0v;
        bus.b0  = b0v;
        bus.a1  = a1v;
        bus.b1  = b1v;
        mul_lat = lat;
        bus.req = r;
        if (r == 2'b11) g = ref_last ? 0 : 1;
        else            g = r[1] ? 1 : 0;
        ea    = (g == 1) ? a1v : a0v;
        eb    = (g == 1) ? b1v : b0v;
        exp_p = int'(ea) * int'(eb);
        @(negedge clk);
        if (bus.start_mul) starts = 1; else starts = 0;
        bus.a0 = 8'($urandom);
        bus.b0 = 8'($urandom);
        bus.a1 = 8'($urandom);
        bus.b1 = 8'($urandom);
        begin
            int s2;
            wait_ack(400, seen, cyc, s2);
            starts += s2;
        end
        check({tag, ".ack"},    32'(seen), 32'(1 << g));
        check({tag, ".result"}, 32'(bus.result), 32'(exp_p));
        check({tag, ".err"},    32'(bus.err), 32'd0);
        check({tag, ".mul_a"},  32'(bus.mul_a), 32'(ea));
        check({tag, ".mul_b"},  32'(bus.mul_b), 32'(eb));
        check({tag, ".starts"}, 32'(starts), 32'd1);
        ref_last = 1'(g);
        bus.req  = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] seen;
        int         cyc, starts;
        logic [7:0] la1, lb1;

        bus.req = 2'b00;
        bus.a0  = '0;
        bus.b0  = '0;
        bus.a1  = '0;
        bus.b1  = '0;
        repeat (2) @(negedge clk);
        // Reset values, sampled while rst is still high.
        check("rst.busy",   32'(bus.busy), 32'd0);
        check("rst.ack",    32'(bus.ack), 32'd0);
        check("rst.start",  32'(bus.start_mul), 32'd0);
        check("rst.result", 32'(bus.result), 32'd0);
        check("rst.err",    32'(bus.err), 32'd0);
        check("rst.mul_ab", 32'({bus.mul_a, bus.mul_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, 9-cycle multiplier.
        serve(2'b01, 9, 8'd12, 8'd13, 8'd0, 8'd0, "single");
        check("single.result_const", 32'(bus.result), 32'd156);

        // Simultaneous requests right after reset: requester 0 first.
        do_reset();
        serve(2'b11, 5, 8'd3, 8'd5, 8'd7, 8'd9, "sim0");
        check("sim0.result_const", 32'(bus.result), 32'd15);
        serve(2'b11, 5, 8'd3, 8'd5, 8'd7, 8'd9, "sim1");
        check("sim1.result_const", 32'(bus.result), 32'd63);

        // Fairness with both requests held.
        for (int i = 0; i < 4; i++) begin
            serve(2'b11, int'($urandom_range(1, 8)), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), "fair");
        end

        // Reset in the middle of WAIT_DONE.
        mul_lat = 20;
        bus.a0  = 8'd4;
        bus.b0  = 8'd6;
        bus.req = 2'b01;
        repeat (5) @(negedge clk);
        check("rstmid.busy_before", 32'(bus.busy), 32'd1);
        rst     = 1'b1;
        bus.req = 2'b00;
        @(negedge clk);
        check("rstmid.busy",   32'(bus.busy), 32'd0);
        check("rstmid.ack",    32'(bus.ack), 32'd0);
        check("rstmid.result", 32'(bus.result), 32'd0);
        rst      = 1'b0;
        ref_last = 1'b1;
        wait_ack(30, seen, cyc, starts);
        check("rstmid.no_ack", 32'(seen), 32'd0);
        serve(2'b11, 3, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "rstmid.next");

        // 255x255 with a late request from requester 1.
        la1     = 8'($urandom);
        lb1     = 8'($urandom);
        bus.a0  = 8'd255;
        bus.b0  = 8'd255;
        mul_lat = 6;
        bus.req = 2'b01;
        repeat (3) @(negedge clk);
        bus.a1  = la1;
        bus.b1  = lb1;
        bus.req = 2'b11;
        wait_ack(100, seen, cyc, starts);
        check("late.ack0",    32'(seen), 32'd1);
        check("late.result0", 32'(bus.result), 32'd65025);
        check("late.starts0", 32'(starts), 32'd0);
        ref_last = 1'b0;
        bus.req  = 2'b00;
        @(negedge clk);
        serve(2'b10, 4, 8'($urandom), 8'($urandom), la1, lb1, "late.req1");

        // Random traffic.
        for (int i = 0; i < 10; i++) begin
            serve(2'($urandom_range(1, 3)), int'($urandom_range(1, 12)), 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), "rand");
        end

        // Multiplier never finishes.
        mul_stuck = 1'b1;
        bus.a0    = 8'd9;
        bus.b0    = 8'd9;
        bus.req   = 2'b01;
        wait_ack(300, seen, cyc, starts);
`ifdef MULT_ARB_TIMEOUT_EN
        check("tmo.ack",    32'(seen), 32'd1);
        check("tmo.cycles", 32'(cyc), 32'd258);
        check("tmo.err",    32'(bus.err), 32'd1);
        check("tmo.result", 32'(bus.result), 32'd0);
`else
        check("tmo.no_ack", 32'(seen), 32'd0);
        check("tmo.busy",   32'(bus.busy), 32'd1);
        check("tmo.err",    32'(bus.err), 32'd0);
`endif
        check("tmo.starts", 32'(starts), 32'd1);
        mul_stuck = 1'b0;
        do_reset();
        serve(2'b10, 2, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "post_tmo");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req  input  2  per-requester request level, bit i = requester i.
REQ-004 SHALL have port: a0, b0  input  8 each  requester 0 operands.
REQ-005 SHALL have port: a1, b1  input  8 each  requester 1 operands.
REQ-006 SHALL have port: ack  output  2  one-cycle pulse to the served requester, result valid.
REQ-007 SHALL have port: result  output  16  product for the requester being acked.
REQ-008 SHALL have port: err  output  1  valid with ack, marks an aborted operation.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port: start_mul  output  1  start strobe to the shared sequential-multiplier controller.
REQ-011 SHALL have port: mul_a, mul_b  output  8 each  operands to the shared multiplier datapath.
REQ-012 SHALL have port: mul_p  input  16  product from the shared multiplier.
REQ-013 SHALL have port: done_mul  input  1  multiplier done/idle level, high whenever the multiplier is idle.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE, RESP.
REQ-015 IDLE: with any req bit set, SHALL select a requester, latch its operands into mul_a/mul_b, record the grant index and go to START. Otherwise it SHALL stay in IDLE.
REQ-016 Selection SHALL be round-robin: with both requests set, grant the index not granted last. With one request set, grant it.
REQ-017 START: start_mul SHALL be 1 for exactly this one cycle. Next state SHALL be WAIT_BUSY.
REQ-018 WAIT_BUSY: SHALL hold until done_mul=0, then go to WAIT_DONE. This rejects the stale done level.
REQ-019 WAIT_DONE: SHALL hold until done_mul=1, then capture mul_p into result and go to RESP.
REQ-020 RESP: ack[grant] SHALL be 1 for one cycle, last-grant SHALL update to grant, and next state SHALL be IDLE.
REQ-021 mul_a/mul_b SHALL remain stable from START through RESP.
REQ-022 result SHALL hold its value until the next capture.
REQ-023 A req dropped mid-operation SHALL NOT abort the operation; the ack SHALL still be issued.
REQ-024 A req arriving during an operation SHALL wait; it SHALL be considered only in IDLE.
REQ-025 An ack'ed requester still holding req SHALL be re-served, subject to round-robin.
REQ-026 Minimum IDLE-to-ack latency SHALL be 4 cycles plus multiplier busy time.

Reset
REQ-027 On rst: state=IDLE, ack=0, start_mul=0, result=0, err=0, mul_a=mul_b=0, busy=0, last-grant=1 (requester 0 wins first tie).
REQ-028 rst mid-operation SHALL discard the operation with no ack. The multiplier controller SHALL be reset by the same rst.

Configuration
REQ-029 Macro MULT_ARB_TIMEOUT_EN defined: an 8-bit watchdog SHALL clear on entering WAIT_BUSY and count in WAIT_BUSY/WAIT_DONE. At 255 it SHALL force RESP with result=0 and err=1 for the ack cycle.
REQ-030 Macro undefined: no watchdog logic SHALL exist, and err SHALL be constant 0.

Structure
REQ-031 Package mult_arb_pkg SHALL hold the state enum, OP_W=8, PROD_W=16, and TIMEOUT_MAX=255.
REQ-032 Sub-module rr_pick SHALL hold the combinational 2-way round-robin selector: inputs req and last, outputs grant index and valid.

Verification
REQ-033 Single request: req=01, a0=12, b0=13, multiplier model busy 9 cycles -> one start_mul pulse, ack=01, result=156, err=0.
REQ-034 Simultaneous requests from reset: req=11 with (3,5),(7,9) -> ack=01 result=15 first, then ack=10 result=63.
REQ-035 Fairness: req=11 held for 4 operations -> grants alternate 0,1,0,1.
REQ-036 Reset mid-op: rst asserted in WAIT_DONE -> no ack, busy=0 next cycle, next request served normally.
REQ-037 Timeout (macro defined): done_mul stuck 0 -> ack 256 cycles after WAIT_BUSY entry, err=1, result=0. With the macro undefined, the FSM stays in WAIT_DONE.
REQ-038 Operands 255x255 -> result=65025; a late req during the op is served only after the ack.
